bin2bcd_seq: RTL
================

# bin2bcd_seq

Sequential double-dabble converter from an unsigned binary word to packed BCD digits, one bit per clock. It sits between the core's binary status counters (cycle count, PC) and the per-digit `bcd7seg` decoders on the board top level. It replaces the combinational `/10` and `%10` chains with a small shift/add-3 engine behind a start/done handshake.

## Interface
Parameters:
- `WIDTH`, 32: binary input width; must be ≥ 1.
- `DIGITS`, 10: number of BCD output digits; 10 covers a full 32-bit range.

Ports:
- `iCLK`  in  1  system clock; all state updates on its rising edge.
- `iRST_n`  in  1  asynchronous, active-low reset.
- `iStart`  in  1  request a conversion; sampled only when `oBusy`=0.
- `iBin`  in  WIDTH  binary value; captured on the accepting edge.
- `oBCD`  out  4*DIGITS  packed BCD result; digit 0 is `[3:0]`. Registered and held until the next result.
- `oDone`  out  1  one-cycle pulse; `oBCD`/`oOvf` valid and newly updated.
- `oBusy`  out  1  high while a conversion is in progress.
- `oOvf`  out  1  result truncated because `iBin` ≥ 10^DIGITS; updated together with `oBCD`.

## Operation
- **State machine:** IDLE, SHIFT, DONE.
- **IDLE**
  - If `iStart`=1: load the shift register with `iBin`, clear the working BCD register and the overflow sticky bit, set bit counter = 0, and go to SHIFT.
- **SHIFT** (one iteration per cycle)
  - Every working BCD nibble ≥ 5 gets +3.
  - Then shift {BCD, bin} left by 1.
  - A 1 shifted out of the top nibble sets the overflow sticky bit.
  - Counter increments. After the iteration with counter = WIDTH-1, go to DONE.
  - On that same edge, load `oBCD` from the working register and `oOvf` from the sticky bit.
- **DONE**
  - `oDone`=1 for exactly this cycle.
  - `iStart`=1 here is accepted exactly as in IDLE (back-to-back conversions). Otherwise go to IDLE.
- **Widths**
  - Working register: 4*DIGITS bits.
  - Counter: $clog2(WIDTH+1) bits.
  - Add-3 is a 4-bit add with no carry between nibbles.
- **Overflow handling:** `oBCD` holds the low DIGITS decimal digits of `iBin` mod 10^DIGITS; `oOvf`=1.
- **Busy behaviour**
  - `iStart` while `oBusy`=1 is ignored. No queueing, no error.
  - `iBin` changes during SHIFT have no effect.
- **Reset mid-conversion:** all state is cleared immediately, the partial result is discarded, and `oBCD` returns to 0.

## Timing
- **Reset values:** state=IDLE, `oBCD`=0, `oOvf`=0, `oDone`=0, `oBusy`=0.
- **Start:** `iStart` is accepted at edge N. `oBusy`=1 from just after edge N until edge N+WIDTH.
- **Result:** `oBCD`, `oOvf` and `oDone`=1 all update at edge N+WIDTH. `oDone` returns to 0 at edge N+WIDTH+1.
- **Throughput:** one conversion per WIDTH+1 cycles when `iStart` is held high.
- **Control outputs:** `oBusy` and `oDone` are decoded from registered state only and are never high in the same cycle.

## Configuration
- **Macro:** `BIN2BCD_AUTO_EN`.
- **Defined:** the block is free-running.
  - Any cycle in IDLE or DONE starts a new conversion of the current `iBin`; `iStart` is ignored.
  - `oBCD` refreshes every WIDTH+1 cycles, so a live counter can feed the display with no controller logic.
- **Undefined:** conversions start only on `iStart` as described above; `oBCD` otherwise holds indefinitely.

## Test plan
- **Zero:** reset, then `iStart` with `iBin`=0. Required: `oDone` after 32 cycles, `oBCD`=0x0000000000, `oOvf`=0.
- **Typical and full range:** `iBin`=1234, then `iBin`=32'hFFFFFFFF back-to-back by holding `iStart` across DONE. Required: `oBCD`=0x0000001234, then `oBCD`=0x4294967295, with the two `oDone` pulses 33 cycles apart.
- **Overflow:** with DIGITS=4, `iBin`=12345. Required: `oBCD`=0x2345, `oOvf`=1. A following `iBin`=9999 gives 0x9999 with `oOvf`=0.
- **Busy protection:** pulse `iStart` with `iBin`=7 mid-conversion of 500. Required: the result is 0x500, there is exactly one `oDone`, and `oBusy` timing is unchanged.
- **Reset during conversion:** assert `iRST_n`=0 at cycle 10 of SHIFT, asynchronously. Required: immediately `oBusy`=0, `oBCD`=0, no `oDone`. A new start then works normally.
- **`BIN2BCD_AUTO_EN` defined:** change `iBin` from 42 to 43 with `iStart` held low. Required: `oDone` repeats every 33 cycles, and `oBCD` becomes 0x43 within two periods.

Source files
------------

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble converter from an unsigned binary word
//            to packed BCD digits, one input bit per clock, with a start/done
//            handshake. The result is the low DIGITS decimal digits; oOvf
//            flags values that did not fit.
// Options  : BIN2BCD_AUTO_EN - when defined the block is free-running and
//            restarts on every IDLE/DONE cycle using the current iBin;
//            iStart is then ignored.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                  iCLK,
   input  logic                  iRST_n,
   input  logic                  iStart,
   input  logic [WIDTH-1:0]      iBin,
   output logic [4*DIGITS-1:0]   oBCD,
   output logic                  oDone,
   output logic                  oBusy,
   output logic                  oOvf
);

   localparam int              BW     = 4 * DIGITS;
   localparam int              CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   bin_q,   bin_d;
   logic [BW-1:0]      bcd_q,   bcd_d;
   logic               ovf_q,   ovf_d;
   logic [CW-1:0]      cnt_q,   cnt_d;
   logic [BW-1:0]      obcd_q,  obcd_d;
   logic               oovf_q,  oovf_d;

   logic [BW-1:0]      w_adj;
   logic [BW-1:0]      w_shift_bcd;
   logic [WIDTH-1:0]   w_shift_bin;
   logic               w_ovf_next;
   logic               w_go;

   // Per-digit add-3 correction; nibbles never carry into each other.
   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_nib
         assign w_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                            : bcd_q[4*i +: 4];
      end
   endgenerate

   // One doubling step of {BCD, bin}; the bit leaving the top digit is lost
   // and recorded as overflow, which leaves the result modulo 10^DIGITS.
   assign w_shift_bcd = {w_adj[BW-2:0], bin_q[WIDTH-1]};
   assign w_shift_bin = bin_q << 1;
   assign w_ovf_next  = ovf_q | w_adj[BW-1];

`ifdef BIN2BCD_AUTO_EN
   logic unused_start;
   assign unused_start = iStart;
   assign w_go         = 1'b1;
`else
   assign w_go         = iStart;
`endif

   // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      obcd_d  = obcd_q;
      oovf_d  = oovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (w_go) begin
               bin_d   = iBin;
               bcd_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            bcd_d = w_shift_bcd;
            bin_d = w_shift_bin;
            ovf_d = w_ovf_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_LAST) begin
               state_d = ST_DONE;
               obcd_d  = w_shift_bcd;
               oovf_d  = w_ovf_next;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers; reset discards any partial conversion.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         obcd_q  <= '0;
         oovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         obcd_q  <= obcd_d;
         oovf_q  <= oovf_d;
      end
   end

   assign oBCD  = obcd_q;
   assign oOvf  = oovf_q;
   assign oBusy = (state_q == ST_SHIFT);
   assign oDone = (state_q == ST_DONE);

endmodule
`default_nettype wire
